// File: rtl/tridiag_det_sched_if.sv
// Request / response / engine channels of the tridiagonal determinant scheduler.
// slave = scheduler view, master = host + engine view.
interface tridiag_det_sched_if #(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int R     = 4,
    parameter int IDW   = (R > 2) ? $clog2(R) : 1
);
    logic [R-1:0]             req_valid;
    logic [R-1:0]             req_ready;
    logic [R*WIDTH*(N-1)-1:0] req_a_flat;
    logic [R*WIDTH*N-1:0]     req_b_flat;
    logic [R*WIDTH*(N-1)-1:0] req_c_flat;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [2*WIDTH-1:0]       rsp_det;

    logic                     eng_rst;
    logic                     eng_start;
    logic [WIDTH*(N-1)-1:0]   eng_a_flat;
    logic [WIDTH*N-1:0]       eng_b_flat;
    logic [WIDTH*(N-1)-1:0]   eng_c_flat;
    logic                     eng_done;
    logic [2*WIDTH-1:0]       eng_det;

    logic [31:0]              perf_jobs;
    logic [31:0]              perf_busy;

    modport slave (
        input  req_valid, req_a_flat, req_b_flat, req_c_flat, rsp_ready, eng_done, eng_det,
        output req_ready, rsp_valid, rsp_id, rsp_det, eng_rst, eng_start,
               eng_a_flat, eng_b_flat, eng_c_flat, perf_jobs, perf_busy
    );

    modport master (
        output req_valid, req_a_flat, req_b_flat, req_c_flat, rsp_ready, eng_done, eng_det,
        input  req_ready, rsp_valid, rsp_id, rsp_det, eng_rst, eng_start,
               eng_a_flat, eng_b_flat, eng_c_flat, perf_jobs, perf_busy
    );
endinterface

// File: rtl/tridiag_det_sched.sv
// Round-robin scheduler sharing one tridiagonal determinant engine among R requesters.
// Optional perf counters under `TRIDIAG_SCHED_PERF_EN.
module tridiag_det_sched #(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int R     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tridiag_det_sched_if.slave bus
);
    localparam int IDW = (R > 2) ? $clog2(R) : 1;
    localparam int AW  = WIDTH * (N - 1);
    localparam int BW  = WIDTH * N;
    localparam int DW  = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [AW-1:0] c;
    } ops_t;

    state_t         state, state_nxt;
    ops_t           ops, ops_sel;
    logic [IDW-1:0] last, cur_id, grant;
    logic [IDW-1:0] rsp_id_q;
    logic [DW-1:0]  rsp_det_q;
    logic [R-1:0]   grant_oh;
    logic           found;
    logic           accept;
    int             k;

    // First valid requester searching upward from last+1, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        k     = 0;
        for (int i = 1; i <= R; i++) begin
            k = (int'(last) + i) % R;
            if (!found && bus.req_valid[k]) begin
                found = 1'b1;
                grant = IDW'(k);
            end
        end
    end

    assign grant_oh      = R'(1) << grant;
    assign accept        = (state == IDLE) && found && rst_n;
    assign bus.req_ready = accept ? grant_oh : '0;

    always_comb begin
        ops_sel.a = bus.req_a_flat[int'(grant)*AW +: AW];
        ops_sel.b = bus.req_b_flat[int'(grant)*BW +: BW];
        ops_sel.c = bus.req_c_flat[int'(grant)*AW +: AW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found)         state_nxt = ISSUE;
            ISSUE:                      state_nxt = WAIT;
            WAIT:    if (bus.eng_done)  state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // last resets to R-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops       <= '0;
            last      <= IDW'(R - 1);
            cur_id    <= '0;
            rsp_id_q  <= '0;
            rsp_det_q <= '0;
        end else begin
            if (state == IDLE && found) begin
                ops    <= ops_sel;
                cur_id <= grant;
                last   <= grant;
            end
            if (state == WAIT && bus.eng_done) begin
                rsp_id_q  <= cur_id;
                rsp_det_q <= bus.eng_det;
            end
        end
    end

    assign bus.eng_rst    = !rst_n;
    assign bus.eng_start  = (state == ISSUE);
    assign bus.eng_a_flat = ops.a;
    assign bus.eng_b_flat = ops.b;
    assign bus.eng_c_flat = ops.c;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_det    = rsp_det_q;

`ifdef TRIDIAG_SCHED_PERF_EN
    logic [31:0] jobs_q, busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jobs_q <= '0;
            busy_q <= '0;
        end else begin
            if (state == RESP && bus.rsp_ready) jobs_q <= jobs_q + 32'd1;
            if (state != IDLE)                  busy_q <= busy_q + 32'd1;
        end
    end

    assign bus.perf_jobs = jobs_q;
    assign bus.perf_busy = busy_q;
`else
    assign bus.perf_jobs = '0;
    assign bus.perf_busy = '0;
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
    a_ready_idle:   assert property (@(posedge clk) disable iff (!rst_n)
                                     (bus.req_ready != '0) |-> (state == IDLE));
endmodule
